// File: rtl/cpu_pkg.sv
// Shared CPU definitions: control-store geometry, loader FSM states and the
// frame header sanity check.
package cpu_pkg;

  localparam int unsigned CSTORE_ADDR_W = 11;
  localparam int unsigned CSTORE_WORDS  = 2048;
  localparam int unsigned CTRL_WORD_W   = 16;
  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned FIELD_W       = 16;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_CNT_HI,
    ST_CNT_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_WRITE,
    ST_CHECK
  } ld_state_e;

  // A frame is loadable when it is non-empty and fits entirely in the store.
  function automatic logic frame_ok(input logic [FIELD_W-1:0] addr,
                                    input logic [FIELD_W-1:0] cnt);
    logic [FIELD_W:0] span_end;
    span_end = (FIELD_W+1)'(addr[CSTORE_ADDR_W-1:0]) + (FIELD_W+1)'(cnt);
    return (cnt != '0) &&
           (addr[FIELD_W-1:CSTORE_ADDR_W] == '0) &&
           (span_end <= (FIELD_W+1)'(CSTORE_WORDS));
  endfunction

endpackage

// File: rtl/ucode_loader_timeout.sv
// Idle-cycle watchdog for an open frame; expired_o is high during the cycle in
// which the idle count reaches TIMEOUT_CYCLES.
module ucode_loader_timeout
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             expired_q;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      expired_q <= enable_i && !clear_i && (count_d == CNT_W'(TIMEOUT_CYCLES - 1));
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/ucode_loader.sv
// Microcode loader: parses framed bytes from the host link and writes control
// words into the control store while holding the CPU in reset.
module ucode_loader
  import cpu_pkg::*;
#(
  parameter int unsigned           TIMEOUT_CYCLES = 65535,
  parameter logic [BYTE_W-1:0]     HEADER         = 8'hA5
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [BYTE_W-1:0]        i_rxData,
  input  logic                     i_rxValid,
  output logic                     o_rxReady,
  output logic [CSTORE_ADDR_W-1:0] o_memAddr,
  output logic [CTRL_WORD_W-1:0]   o_memData,
  output logic                     o_memWe,
  output logic                     o_cpuHold,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_error
);

  ld_state_e                state_q;
  logic [FIELD_W-1:0]       addr_q;
  logic [FIELD_W-1:0]       remaining_q;
  logic [BYTE_W-1:0]        data_hi_q;
  logic [BYTE_W-1:0]        sum_q;
  logic                     rx_ready_q;
  logic [CSTORE_ADDR_W-1:0] mem_addr_q;
  logic [CTRL_WORD_W-1:0]   mem_data_q;
  logic                     mem_we_q;
  logic                     cpu_hold_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     error_q;

  logic accept_c;
  logic tmo_expired;

  assign accept_c = i_rxValid && rx_ready_q;

  ucode_loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .clear_i  (accept_c || (state_q == ST_IDLE)),
    .enable_i (state_q != ST_IDLE),
    .expired_o(tmo_expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      data_hi_q   <= '0;
      sum_q       <= '0;
      rx_ready_q  <= 1'b1;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_we_q    <= 1'b0;
      cpu_hold_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      // Hold is released the cycle after the terminating pulse.
      if (done_q || error_q) begin
        cpu_hold_q <= 1'b0;
      end

      if ((state_q != ST_IDLE) && (state_q != ST_WRITE) && !accept_c && tmo_expired) begin
        error_q <= 1'b1;
        busy_q  <= 1'b0;
        state_q <= ST_IDLE;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (accept_c && (i_rxData == HEADER)) begin
              state_q    <= ST_ADDR_HI;
              busy_q     <= 1'b1;
              cpu_hold_q <= 1'b1;
              sum_q      <= '0;
            end
          end
          ST_ADDR_HI: begin
            if (accept_c) begin
              addr_q[FIELD_W-1:BYTE_W] <= i_rxData;
              state_q                  <= ST_ADDR_LO;
            end
          end
          ST_ADDR_LO: begin
            if (accept_c) begin
              addr_q[BYTE_W-1:0] <= i_rxData;
              state_q            <= ST_CNT_HI;
            end
          end
          ST_CNT_HI: begin
            if (accept_c) begin
              remaining_q[FIELD_W-1:BYTE_W] <= i_rxData;
              state_q                       <= ST_CNT_LO;
            end
          end
          ST_CNT_LO: begin
            if (accept_c) begin
              remaining_q[BYTE_W-1:0] <= i_rxData;
              if (frame_ok(addr_q, {remaining_q[FIELD_W-1:BYTE_W], i_rxData})) begin
                state_q <= ST_DATA_HI;
              end else begin
                error_q <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end
            end
          end
          ST_DATA_HI: begin
            if (accept_c) begin
              data_hi_q <= i_rxData;
              sum_q     <= sum_q + i_rxData;
              state_q   <= ST_DATA_LO;
            end
          end
          ST_DATA_LO: begin
            if (accept_c) begin
              sum_q      <= sum_q + i_rxData;
              mem_addr_q <= addr_q[CSTORE_ADDR_W-1:0];
              mem_data_q <= {data_hi_q, i_rxData};
              mem_we_q   <= 1'b1;
              rx_ready_q <= 1'b0;
              state_q    <= ST_WRITE;
            end
          end
          ST_WRITE: begin
            rx_ready_q  <= 1'b1;
            addr_q      <= addr_q + FIELD_W'(1);
            remaining_q <= remaining_q - FIELD_W'(1);
            state_q     <= (remaining_q == FIELD_W'(1)) ? ST_CHECK : ST_DATA_HI;
          end
          ST_CHECK: begin
            if (accept_c) begin
              if (BYTE_W'(sum_q + i_rxData) == '0) begin
                done_q <= 1'b1;
              end else begin
                error_q <= 1'b1;
              end
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign o_rxReady = rx_ready_q;
  assign o_memAddr = mem_addr_q;
  assign o_memData = mem_data_q;
  assign o_memWe   = mem_we_q;
  assign o_cpuHold = cpu_hold_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_error   = error_q;

endmodule
